// File: rtl/ysyx_23060020_rf_sb.sv
// Integer register file with per-register busy scoreboard and post-reset clear sweep.
// Define YSYX_23060020_RF_BYPASS_EN to forward same-cycle writeback data to the read ports.
module ysyx_23060020_rf_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRP    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRP*ADDR_W-1:0] raddr,
  output logic [NRP*DATA_W-1:0] rdata,
  output logic [NRP-1:0]        rbusy,
  input  logic                  iss_en,
  input  logic [ADDR_W-1:0]     iss_addr,
  input  logic                  wen,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W-1:0]     wdata,
  output logic                  ready
);

  localparam int NREG = 1 << ADDR_W;

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;
  logic [ADDR_W-1:0] ra [NRP];
  logic              wr_hit;
  logic              iss_hit;

  assign ready   = (state == RUN);
  assign wr_hit  = ready && wen && (waddr != '0);
  assign iss_hit = ready && iss_en && (iss_addr != '0);

  // Issue is applied after writeback so a same-index issue leaves the entry busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      busy    <= '0;
    end else if (state == CLEAR) begin
      busy[clr_ptr] <= 1'b0;
      clr_ptr       <= clr_ptr + ADDR_W'(1);
      if (&clr_ptr) state <= RUN;
    end else begin
      if (wr_hit)  busy[waddr]    <= 1'b0;
      if (iss_hit) busy[iss_addr] <= 1'b1;
    end
  end

  // Storage has no reset; the sweep zeroes it after rst is released.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) regs[clr_ptr] <= '0;
      else if (wr_hit)    regs[waddr]   <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    rbusy = '0;
    ra    = '{default: '0};
    for (int unsigned i = 0; i < unsigned'(NRP); i++) begin
      ra[i] = raddr[i*ADDR_W +: ADDR_W];
      if (ready && (ra[i] != '0)) begin
        rdata[i*DATA_W +: DATA_W] = regs[ra[i]];
        rbusy[i]                  = busy[ra[i]];
`ifdef YSYX_23060020_RF_BYPASS_EN
        if (wr_hit && (waddr == ra[i])) begin
          rdata[i*DATA_W +: DATA_W] = wdata;
          rbusy[i]                  = iss_hit && (iss_addr == waddr);
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060020_rf_sb.sv
// Scoreboard bench for ysyx_23060020_rf_sb: driver pushes predicted read-port values,
// a negedge monitor pops and compares them against the DUT.
module tb_ysyx_23060020_rf_sb;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NRP  = 2;
  localparam int NREG = 32;

  logic                 clk;
  logic                 rst;
  logic [NRP*AW-1:0]    raddr;
  logic [NRP*DW-1:0]    rdata;
  logic [NRP-1:0]       rbusy;
  logic                 iss_en;
  logic [AW-1:0]        iss_addr;
  logic                 wen;
  logic [AW-1:0]        waddr;
  logic [DW-1:0]        wdata;
  logic                 ready;

  ysyx_23060020_rf_sb #(.DATA_W(DW), .ADDR_W(AW), .NRP(NRP)) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .iss_en(iss_en), .iss_addr(iss_addr), .wen(wen), .waddr(waddr),
    .wdata(wdata), .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural register contents, busy flags, sweep countdown.
  logic [DW-1:0] mregs [NREG];
  logic          mbusy [NREG];
  logic          mready;
  int            sweep_left;

  typedef struct packed {
    logic [NRP*DW-1:0] d;
    logic [NRP-1:0]    b;
    logic              r;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t predict();
    exp_t e;
    logic [AW-1:0] a;
    e.r = mready;
    e.d = '0;
    e.b = '0;
    for (int i = 0; i < NRP; i++) begin
      a = raddr[i*AW +: AW];
      if (mready && a != 0) begin
        e.d[i*DW +: DW] = mregs[a];
        e.b[i]          = mbusy[a];
`ifdef YSYX_23060020_RF_BYPASS_EN
        if (wen && waddr != 0 && waddr == a) begin
          e.d[i*DW +: DW] = wdata;
          e.b[i]          = iss_en && (iss_addr == waddr);
        end
`endif
      end
    end
    return e;
  endfunction

  task automatic model_edge();
    if (rst) begin
      mready     = 1'b0;
      sweep_left = NREG;
      for (int i = 0; i < NREG; i++) mbusy[i] = 1'b0;
    end else if (!mready) begin
      sweep_left--;
      if (sweep_left == 0) begin
        for (int i = 0; i < NREG; i++) begin
          mregs[i] = '0;
          mbusy[i] = 1'b0;
        end
        mready = 1'b1;
      end
    end else begin
      if (wen && waddr != 0) begin
        mregs[waddr] = wdata;
        mbusy[waddr] = 1'b0;
      end
      if (iss_en && iss_addr != 0) mbusy[iss_addr] = 1'b1;
    end
  endtask

  task automatic step(input logic r, input logic ie, input logic [AW-1:0] ia,
                      input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    rst      = r;
    iss_en   = ie;
    iss_addr = ia;
    wen      = we;
    waddr    = wa;
    wdata    = wd;
    raddr    = {r1, r0};
    sbq.push_back(predict());
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    step(1'b0, 1'b0, '0, 1'b0, '0, '0, r0, r1);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 7));
    return AW'($urandom_range(0, NREG - 1));
  endfunction

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      check("rdata", 64'(rdata), 64'(mon_e.d));
      check("rbusy", 64'(rbusy), 64'(mon_e.b));
      check("ready", 64'(ready), 64'(mon_e.r));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; iss_en = 1'b0; iss_addr = '0; wen = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    for (int i = 0; i < NREG; i++) begin
      mregs[i] = '0;
      mbusy[i] = 1'b0;
    end
    @(posedge clk);
    #1;
    mready     = 1'b0;
    sweep_left = NREG;
    step(1'b1, 1'b0, '0, 1'b0, '0, '0, 5'd1, 5'd2);

    n = 0;
    while (!ready && n < 100) begin
      idle(5'd1, 5'd2);
      n++;
    end
    check("sweep_len", 64'(n), 64'd32);

    for (int a = 1; a < NREG; a++) idle(AW'(a), AW'(NREG - a));

    // Reset mid-sweep: clr_ptr reaches 10, then restart.
    step(1'b1, 1'b0, '0, 1'b0, '0, '0, 5'd0, 5'd0);
    for (int i = 0; i < 10; i++) idle(5'd4, 5'd9);
    step(1'b1, 1'b0, '0, 1'b0, '0, '0, 5'd0, 5'd0);
    n = 0;
    while (!ready && n < 100) begin
      step(1'b0, 1'b1, 5'd6, 1'b1, 5'd6, 32'h0bad_0bad, 5'd6, 5'd6);
      n++;
    end
    check("sweep_restart_len", 64'(n), 64'd32);

    step(1'b0, 1'b1, 5'd5, 1'b0, '0, '0, 5'd5, 5'd0);
    idle(5'd5, 5'd5);
    step(1'b0, 1'b0, '0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0);
    idle(5'd5, 5'd5);
    step(1'b0, 1'b1, 5'd7, 1'b1, 5'd7, 32'h0000_1234, 5'd7, 5'd7);
    idle(5'd7, 5'd7);
    step(1'b0, 1'b1, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    idle(5'd0, 5'd0);
    step(1'b0, 1'b0, '0, 1'b1, 5'd3, 32'h1111_1111, 5'd0, 5'd0);
    step(1'b0, 1'b0, '0, 1'b1, 5'd3, 32'hA5A5_A5A5, 5'd0, 5'd3);
    idle(5'd0, 5'd3);
    step(1'b0, 1'b1, 5'd9, 1'b1, 5'd9, 32'hCAFE_F00D, 5'd9, 5'd9);
    idle(5'd9, 5'd9);

    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 149) == 0, 1'($urandom_range(0, 1)), rand_addr(),
           1'($urandom_range(0, 1)), rand_addr(), $urandom(), rand_addr(), rand_addr());
    end

    idle(5'd0, 5'd0);
    @(negedge clk);
    #1;
    check("sb_drain", 64'(sbq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
